dt_share_arb: RTL and testbench
===============================

// Module: dt_share_arb
// PURPOSE
//  Time-shares the 4-digit 7-segment display (dt_module num1..num4) among NREQ
//  requesters (IR code, key counters, etc.). Requests are latched, then granted
//  round-robin. The winner's 16-bit value is held on the display for HOLD_MS ms.
//  With nothing pending, the display tracks background source DEFAULT_SRC live.
//  Sits between the requesters and dt_module in top.
// PARAMETERS
//  NREQ         4           number of requesters, 2..4
//  CLK_HZ       48_000_000  clk frequency, Hz
//  TICK_HZ      1000        hold-timer tick rate; CLK_HZ/TICK_HZ must be an integer >= 2
//  HOLD_MS      2000        display hold per grant, in ticks (>= 1)
//  DEFAULT_SRC  0           requester index shown live while idle
// PORTS
//  clk          in   1        system clock (48 MHz)
//  rst_n        in   1        reset, asynchronous, active-low
//  req          in   NREQ     per-requester 1-cycle request pulse
//  req_data     in   NREQ*16  value of requester i = [16i+15:16i]; stable from req until grant
//  num1..num4   out  4 each   digit nibbles to dt_module; num1=data[3:0] .. num4=data[15:12]
//  owner        out  2        index of the displayed source
//  owner_valid  out  1        1 while a granted (non-background) value is shown
//  grant        out  NREQ     one-hot, high for exactly 1 cycle when request i is served
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  Reset: async, active-low, drives immediately num*=0, owner=DEFAULT_SRC,
//   owner_valid=0, grant=0, busy=0, pend=0, last=NREQ-1, state=IDLE, timer=0, prescaler=0.
//  Tick: free-running prescaler. Pulses tick for 1 cycle every CLK_HZ/TICK_HZ clocks.
//  pend[i]: set at the edge sampling req[i]=1; cleared in GRANT for the winner.
//   A req on a winner's GRANT cycle is absorbed (no new pend).
//  FSM IDLE -> GRANT -> HOLD:
//   IDLE:  num* <= req_data[DEFAULT_SRC] every cycle (1-cycle latency); owner=DEFAULT_SRC.
//          If any pend: -> GRANT.
//   GRANT: 1 cycle. Winner w = first set pend scanning last+1, last+2 .. (mod NREQ).
//          grant[w]=1. At the edge: num* <= req_data[w], owner<=w, owner_valid<=1,
//          last<=w, timer<=HOLD_MS, pend[w]<=0. -> HOLD.
//   HOLD:  each tick: timer--. When timer==0: -> GRANT if any pend, else
//          -> IDLE (owner_valid<=0).
//  Latency: req sampled at edge k -> GRANT during cycle after k+1 -> display updated at k+2.
//  Refresh: req[owner] in HOLD with no other pend set ->
//   re-latch req_data[owner], timer<=HOLD_MS, grant[owner] pulse that cycle.
//   Refresh beats expiry in the same cycle.
//   If any other pend is set, req[owner] only sets pend[owner] (no starvation).
//  Hold duration: between (HOLD_MS-1)*CLK_HZ/TICK_HZ+1 and HOLD_MS*CLK_HZ/TICK_HZ cycles.
//  No data arithmetic. Timer width = clog2(HOLD_MS+1). Prescaler wraps at CLK_HZ/TICK_HZ-1.
//  Out-of-range DEFAULT_SRC is illegal (elaboration check).
// STRUCTURE
//  Package dt_arb_pkg: state enum {IDLE, GRANT, HOLD}, DATA_W=16, DIG_W=4, OWN_W=2.
//  Sub-module ms_tick_gen (prescaler -> 1-cycle tick). The rest is flat:
//  pend regs, round-robin pick, FSM, output regs.
// TESTING (CLK_HZ=8000, TICK_HZ=1000 => tick every 8 clk; HOLD_MS=3; NREQ=4; DEFAULT_SRC=0)
//  1 Reset, req_data[15:0]=16'h1234 -> num4..num1 = 1,2,3,4 one cycle after release;
//    busy=0, owner_valid=0.
//  2 req[2] pulse with data 16'hABCD -> grant=4'b0100 for 1 cycle; display ABCD 2 cycles
//    after the sample edge; owner=2; IDLE again after 17..24 cycles; display reverts to h1234.
//  3 req[1] and req[3] together (data 1111/3333) -> grant[1] first; at expiry grant[3]
//    with no IDLE cycle between; then IDLE.
//  4 Owner 2 mid-hold issues req[2] with 16'h5555, nothing else pending -> same-cycle
//    grant[2], display 5555, expiry pushed to 17..24 cycles after the refresh.
//  5 Owner 1 holding, req[2] pending, req[1] pulses again -> no refresh; at expiry grant[2],
//    then grant[1] (round-robin).
//  6 rst_n low mid-HOLD with pend set -> outputs 0 immediately (async); after release
//    no grant issued.

Source files
------------

// File: rtl/dt_arb_pkg.sv
// rtl/dt_arb_pkg.sv - shared types and widths for the display time-share arbiter
package dt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    localparam int DATA_W = 16;
    localparam int DIG_W  = 4;
    localparam int OWN_W  = 2;

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - free-running prescaler producing a 1-cycle tick every DIV clocks
module ms_tick_gen #(
    parameter int DIV = 48000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/dt_share_arb.sv
// rtl/dt_share_arb.sv - round-robin time-sharing of the 4-digit display among requesters
module dt_share_arb
    import dt_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int CLK_HZ      = 48_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int HOLD_MS     = 2000,
    parameter int DEFAULT_SRC = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [DIG_W-1:0]         num1,
    output logic [DIG_W-1:0]         num2,
    output logic [DIG_W-1:0]         num3,
    output logic [DIG_W-1:0]         num4,
    output logic [OWN_W-1:0]         owner,
    output logic                     owner_valid,
    output logic [NREQ-1:0]          grant,
    output logic                     busy
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int TMR_W = $clog2(HOLD_MS + 1);
    localparam logic [OWN_W-1:0] DEF_IDX  = OWN_W'(DEFAULT_SRC);
    localparam logic [OWN_W-1:0] LAST_RST = OWN_W'(NREQ - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_MS);

    if (DEFAULT_SRC < 0 || DEFAULT_SRC >= NREQ) begin : g_bad_default
        $error("dt_share_arb: DEFAULT_SRC out of range");
    end
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("dt_share_arb: NREQ must be 2..4");
    end
    if (DIV < 2 || DIV * TICK_HZ != CLK_HZ || HOLD_MS < 1) begin : g_bad_timing
        $error("dt_share_arb: bad CLK_HZ/TICK_HZ/HOLD_MS");
    end

    logic [DATA_W-1:0] words [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_W +: DATA_W];
    end

    arb_state_e        state_q;
    logic [NREQ-1:0]   pend_q, pend_d;
    logic [OWN_W-1:0]  last_q;
    logic [TMR_W-1:0]  timer_q;
    logic [DATA_W-1:0] num_q;
    logic [OWN_W-1:0]  owner_q;
    logic              owner_valid_q;

    logic              tick;
    logic [OWN_W-1:0]  win_idx;
    logic [NREQ-1:0]   win_mask, owner_mask;
    logic              others_pend, refresh;

    ms_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Round-robin: first pending requester after the last one served
    always_comb begin
        logic             found;
        logic [OWN_W-1:0] cand;
        win_idx = last_q;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OWN_W'((int'(last_q) + k) % NREQ);
            if (!found && pend_q[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign win_mask    = NREQ'(1) << win_idx;
    assign owner_mask  = NREQ'(1) << owner_q;
    assign others_pend = |(pend_q & ~owner_mask);
    // The holder may extend its slot only while nobody else is waiting
    assign refresh     = (state_q == HOLD) && req[owner_q] && !others_pend;

    always_comb begin
        pend_d = pend_q | req;
        if (state_q == GRANT) begin
            pend_d = pend_d & ~win_mask;
        end
        if (refresh) begin
            pend_d = pend_d & ~owner_mask;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == GRANT) begin
            grant = win_mask;
        end else if (refresh) begin
            grant = owner_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pend_q        <= '0;
            last_q        <= LAST_RST;
            timer_q       <= '0;
            num_q         <= '0;
            owner_q       <= DEF_IDX;
            owner_valid_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    num_q         <= words[DEF_IDX];
                    owner_q       <= DEF_IDX;
                    owner_valid_q <= 1'b0;
                    if (|pend_q) begin
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    num_q         <= words[win_idx];
                    owner_q       <= win_idx;
                    owner_valid_q <= 1'b1;
                    last_q        <= win_idx;
                    timer_q       <= HOLD_LD;
                    state_q       <= HOLD;
                end
                HOLD: begin
                    if (refresh) begin
                        num_q   <= words[owner_q];
                        timer_q <= HOLD_LD;
                    end else if (tick) begin
                        if (timer_q <= TMR_W'(1)) begin
                            timer_q <= '0;
                            if (|pend_d) begin
                                state_q <= GRANT;
                            end else begin
                                state_q       <= IDLE;
                                owner_q       <= DEF_IDX;
                                owner_valid_q <= 1'b0;
                            end
                        end else begin
                            timer_q <= timer_q - TMR_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign num1        = num_q[3:0];
    assign num2        = num_q[7:4];
    assign num3        = num_q[11:8];
    assign num4        = num_q[15:12];
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dt_share_arb.sv
// tb/tb_dt_share_arb.sv - scoreboard bench for dt_share_arb
module tb_dt_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [63:0] req_data = 64'h0;
    logic [3:0]  num1, num2, num3, num4;
    logic [1:0]  owner;
    logic        owner_valid;
    logic [3:0]  grant;
    logic        busy;

    dt_share_arb #(
        .NREQ(4), .CLK_HZ(8000), .TICK_HZ(1000), .HOLD_MS(3), .DEFAULT_SRC(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .owner(owner), .owner_valid(owner_valid), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          pass_cnt = 0;
    int          tot_cnt = 0;
    logic        disp_pend = 1'b0;
    logic [15:0] disp_exp;
    logic [1:0]  own_exp;
    wire  [15:0] disp = {num4, num3, num2, num1};

    // Scoreboard: each grant pops the next expected service, display checked the cycle after
    always @(negedge clk) begin
        if (!rst_n) begin
            disp_pend = 1'b0;
        end else begin
            if (disp_pend) begin
                tot_cnt++;
                if (disp !== disp_exp || owner !== own_exp || owner_valid !== 1'b1)
                    $display("FAIL sb_display: got %h owner %0d valid %b, want %h owner %0d valid 1",
                             disp, owner, owner_valid, disp_exp, own_exp);
                else pass_cnt++;
                disp_pend = 1'b0;
            end
            if (grant !== 4'b0) begin
                tot_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_grant: got %b, want no grant", grant);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (grant !== 4'(1 << mon_e.idx))
                        $display("FAIL sb_grant: got %b, want %b", grant, 4'(1 << mon_e.idx));
                    else pass_cnt++;
                    disp_pend = 1'b1;
                    disp_exp  = mon_e.data;
                    own_exp   = 2'(mon_e.idx);
                end
            end
        end
    end

    task automatic set_word(input int i, input logic [15:0] v);
        req_data[i*16 +: 16] = v;
    endtask

    task automatic push_exp(input int i, input logic [15:0] v);
        exp_t e;
        e.idx = i;
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        req = 4'b0;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic [3:0] m);
        @(posedge clk);
        #1 req = m;
        @(posedge clk);
        #1 req = 4'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (!busy) break;
        end
    endtask

    task automatic wait_grant(output logic [3:0] g);
        g = 4'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (grant !== 4'b0) begin
                g = grant;
                break;
            end
        end
    endtask

    task automatic test_reset();
        set_word(0, 16'h1234);
        rst_n = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if (disp !== 16'h0 || busy !== 1'b0 || owner_valid !== 1'b0 || grant !== 4'b0 || owner !== 2'd0)
            $display("FAIL reset_state: disp %h busy %b ov %b grant %b owner %0d, want 0000 0 0 0000 0",
                     disp, busy, owner_valid, grant, owner);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if (disp !== 16'h1234) $display("FAIL reset_idle_disp: got %h, want 1234", disp);
        else pass_cnt++;
        tot_cnt++;
        if (busy !== 1'b0 || owner_valid !== 1'b0)
            $display("FAIL reset_idle_flags: busy %b ov %b, want 0 0", busy, owner_valid);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int cyc;
        set_word(2, 16'hABCD);
        @(posedge clk);
        #1 req = 4'b0100;
        push_exp(2, 16'hABCD);
        @(posedge clk);
        #1 req = 4'b0;
        @(negedge clk);
        tot_cnt++;
        if (grant !== 4'b0) $display("FAIL single_early_grant: got %b, want 0000", grant);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (grant !== 4'b0100) $display("FAIL single_grant_latency: got %b, want 0100", grant);
        else pass_cnt++;
        wait_idle(cyc);
        tot_cnt++;
        if (cyc < 18 || cyc > 25) $display("FAIL single_hold_len: got %0d, want 18..25", cyc);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (disp !== 16'h1234 || owner !== 2'd0 || owner_valid !== 1'b0)
            $display("FAIL single_revert: got %h owner %0d ov %b, want 1234 0 0", disp, owner, owner_valid);
        else pass_cnt++;
    endtask

    task automatic test_two_req();
        logic [3:0] g;
        logic       went_idle;
        int         cyc;
        do_reset();
        set_word(1, 16'h1111);
        set_word(3, 16'h3333);
        @(posedge clk);
        #1 req = 4'b1010;
        push_exp(1, 16'h1111);
        push_exp(3, 16'h3333);
        @(posedge clk);
        #1 req = 4'b0;
        wait_grant(g);
        tot_cnt++;
        if (g !== 4'b0010) $display("FAIL two_first: got %b, want 0010", g);
        else pass_cnt++;
        went_idle = 1'b0;
        g = 4'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) went_idle = 1'b1;
            if (grant !== 4'b0) begin
                g = grant;
                break;
            end
        end
        tot_cnt++;
        if (g !== 4'b1000) $display("FAIL two_second: got %b, want 1000", g);
        else pass_cnt++;
        tot_cnt++;
        if (went_idle !== 1'b0) $display("FAIL two_no_idle_gap: got idle %b, want 0", went_idle);
        else pass_cnt++;
        wait_idle(cyc);
        tot_cnt++;
        if (cyc >= 300 || exp_q.size() != 0)
            $display("FAIL two_drain: cycles %0d left %0d, want <300 and 0", cyc, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_refresh();
        logic [3:0] g;
        int         cyc;
        do_reset();
        set_word(2, 16'hABCD);
        push_exp(2, 16'hABCD);
        pulse(4'b0100);
        wait_grant(g);
        repeat (6) @(negedge clk);
        set_word(2, 16'h5555);
        @(posedge clk);
        #1 req = 4'b0100;
        push_exp(2, 16'h5555);
        @(negedge clk);
        tot_cnt++;
        if (grant !== 4'b0100) $display("FAIL refresh_same_cycle: got %b, want 0100", grant);
        else pass_cnt++;
        @(posedge clk);
        #1 req = 4'b0;
        wait_idle(cyc);
        tot_cnt++;
        if (cyc < 18 || cyc > 25) $display("FAIL refresh_hold_len: got %0d, want 18..25", cyc);
        else pass_cnt++;
    endtask

    task automatic test_no_starve();
        logic [3:0] g;
        int         cyc;
        do_reset();
        set_word(1, 16'h1111);
        push_exp(1, 16'h1111);
        pulse(4'b0010);
        wait_grant(g);
        repeat (3) @(negedge clk);
        set_word(2, 16'h2222);
        push_exp(2, 16'h2222);
        pulse(4'b0100);
        set_word(1, 16'h1112);
        @(posedge clk);
        #1 req = 4'b0010;
        push_exp(1, 16'h1112);
        @(negedge clk);
        tot_cnt++;
        if (grant !== 4'b0) $display("FAIL starve_no_refresh: got %b, want 0000", grant);
        else pass_cnt++;
        @(posedge clk);
        #1 req = 4'b0;
        wait_grant(g);
        tot_cnt++;
        if (g !== 4'b0100) $display("FAIL starve_next: got %b, want 0100", g);
        else pass_cnt++;
        wait_grant(g);
        tot_cnt++;
        if (g !== 4'b0010) $display("FAIL starve_back: got %b, want 0010", g);
        else pass_cnt++;
        wait_idle(cyc);
        tot_cnt++;
        if (cyc >= 300 || exp_q.size() != 0)
            $display("FAIL starve_drain: cycles %0d left %0d, want <300 and 0", cyc, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [3:0] g;
        int         n_grant;
        int         n_busy;
        do_reset();
        set_word(3, 16'h3333);
        push_exp(3, 16'h3333);
        pulse(4'b1000);
        wait_grant(g);
        set_word(1, 16'h1111);
        pulse(4'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tot_cnt++;
        if (disp !== 16'h0 || owner_valid !== 1'b0 || busy !== 1'b0 || grant !== 4'b0 || owner !== 2'd0)
            $display("FAIL async_reset: disp %h ov %b busy %b grant %b owner %0d, want 0000 0 0 0000 0",
                     disp, owner_valid, busy, grant, owner);
        else pass_cnt++;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_grant = 0;
        n_busy  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant !== 4'b0) n_grant++;
            if (busy !== 1'b0) n_busy++;
        end
        tot_cnt++;
        if (n_grant != 0 || n_busy != 0)
            $display("FAIL async_no_grant: grants %0d busy %0d, want 0 0", n_grant, n_busy);
        else pass_cnt++;
        tot_cnt++;
        if (disp !== 16'h1234) $display("FAIL async_idle_disp: got %h, want 1234", disp);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_req();
        test_refresh();
        test_no_starve();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", pass_cnt, tot_cnt);
        $fatal(1, "watchdog");
    end

endmodule
